// File: rtl/key_seq_capture_if.sv
// key_seq_capture_if: button/control/result bundle between the debouncer bank,
// the game FSM and the key-sequence capture unit. The master side drives buttons
// and control pulses; the slave side (the capture unit) returns the sequence.
interface key_seq_capture_if #(
  parameter int NUM_BTN = 8,
  parameter int MAX_LEN = 8,
  parameter int KEY_W   = 4,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
);
  logic [NUM_BTN-1:0]       btn_clean;
  logic                     arm;
  logic                     abort;
  logic [CNT_W-1:0]         len_k;
  logic                     time_up;
  logic                     done_ack;
  logic [KEY_W-1:0]         key_code;
  logic                     key_valid;
  logic [MAX_LEN*KEY_W-1:0] seq_out;
  logic [CNT_W-1:0]         seq_cnt;
  logic                     done;
  logic [1:0]               result;
  logic                     collision;

  modport master (
    output btn_clean, arm, abort, len_k, time_up, done_ack,
    input  key_code, key_valid, seq_out, seq_cnt, done, result, collision
  );

  modport slave (
    input  btn_clean, arm, abort, len_k, time_up, done_ack,
    output key_code, key_valid, seq_out, seq_cnt, done, result, collision
  );
endinterface

// File: rtl/key_seq_capture.sv
// key_seq_capture: turns debounced button levels into rising-edge key codes
// (button b -> code b+1) and packs up to MAX_LEN of them into seq_out.
// Finishes on reaching the armed length, on the global round timer, or on an
// inter-key idle timeout (TIMEOUT_CYC > 0); done is held until done_ack.
// Optional feature macro: KEY_BACKSPACE_EN -- the highest-index button acts as
// backspace instead of producing code NUM_BTN.
module key_seq_capture #(
  parameter int NUM_BTN     = 8,
  parameter int MAX_LEN     = 8,
  parameter int KEY_W       = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input logic              clk,
  input logic              rst,
  key_seq_capture_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(NUM_BTN);
  localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT_CYC);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_DONE = 2'b01;
  localparam logic [1:0] RES_GTO  = 2'b10;
  localparam logic [1:0] RES_ITO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_BTN-1:0]       btn_prev_q, btn_prev_d;
  logic [CNT_W-1:0]         len_lat_q, len_lat_d;
  logic [MAX_LEN*KEY_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [KEY_W-1:0]         key_code_q, key_code_d;
  logic                     key_valid_q, key_valid_d;
  logic                     done_q, done_d;
  logic [1:0]               result_q, result_d;
  logic                     collision_q, collision_d;
  logic [TMR_W-1:0]         idle_q, idle_d;

  logic [NUM_BTN-1:0] edge_s;
  logic               any_edge_s;
  logic               multi_edge_s;
  logic [IDX_W-1:0]   low_idx_s;
  logic [KEY_W-1:0]   code_s;
  logic               is_bksp_s;
  logic               accept_key_s;
  logic               final_s;
  logic               idle_hit_s;
  logic [TMR_W-1:0]   idle_inc_s;
  logic [CNT_W-1:0]   len_clamp_s;

  assign edge_s       = bus.btn_clean & ~btn_prev_q;
  assign any_edge_s   = |edge_s;
  assign multi_edge_s = |(edge_s & (edge_s - NUM_BTN'(1)));
  assign code_s       = KEY_W'(low_idx_s) + KEY_W'(1);
  assign accept_key_s = any_edge_s && !is_bksp_s;
  assign final_s      = (cnt_q + CNT_W'(1)) == len_lat_q;
  assign idle_hit_s   = (TIMEOUT_CYC != 0) && (idle_q == TMR_LIM);
  assign idle_inc_s   = (idle_q == TMR_MAX) ? idle_q : idle_q + TMR_W'(1);
  assign len_clamp_s  = (bus.len_k > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : bus.len_k;

`ifdef KEY_BACKSPACE_EN
  // Backspace wins only when it is the lowest-index edge this cycle.
  assign is_bksp_s = any_edge_s && (low_idx_s == IDX_W'(NUM_BTN - 1));
`else
  assign is_bksp_s = 1'b0;
`endif

  // Lowest set edge index: scanning downward leaves the smallest index last.
  always_comb begin
    low_idx_s = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      low_idx_s = edge_s[i] ? IDX_W'(i) : low_idx_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort beats arm, both beat anything the state would do.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else if (bus.arm) begin
      state_d = (len_clamp_s == '0) ? ST_DONE : ST_CAPTURE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_CAPTURE: begin
          if (bus.time_up || idle_hit_s || (accept_key_s && final_s)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_DONE:    state_d = bus.done_ack ? ST_IDLE : ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values; DONE and IDLE leave everything frozen.
  always_comb begin
    btn_prev_d  = bus.btn_clean;
    len_lat_d   = len_lat_q;
    seq_d       = seq_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    done_d      = done_q;
    result_d    = result_q;
    collision_d = collision_q;
    idle_d      = idle_q;
    if (bus.abort) begin
      done_d   = 1'b0;
      result_d = RES_NONE;
    end else if (bus.arm) begin
      len_lat_d   = len_clamp_s;
      seq_d       = '0;
      cnt_d       = '0;
      key_code_d  = '0;
      collision_d = 1'b0;
      idle_d      = '0;
      done_d      = (len_clamp_s == '0);
      result_d    = (len_clamp_s == '0) ? RES_DONE : RES_NONE;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (bus.time_up) begin
            done_d   = 1'b1;
            result_d = RES_GTO;
          end else if (idle_hit_s) begin
            done_d   = 1'b1;
            result_d = RES_ITO;
          end else if (is_bksp_s) begin
            if (cnt_q != '0) begin
              for (int i = 0; i < MAX_LEN; i++) begin
                seq_d[i*KEY_W +: KEY_W] = (CNT_W'(i) == cnt_q - CNT_W'(1)) ?
                                          KEY_W'(0) : seq_q[i*KEY_W +: KEY_W];
              end
              cnt_d  = cnt_q - CNT_W'(1);
              idle_d = '0;
            end else begin
              idle_d = idle_inc_s;
            end
          end else if (accept_key_s) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              seq_d[i*KEY_W +: KEY_W] = (CNT_W'(i) == cnt_q) ?
                                        code_s : seq_q[i*KEY_W +: KEY_W];
            end
            cnt_d       = cnt_q + CNT_W'(1);
            key_code_d  = code_s;
            key_valid_d = 1'b1;
            idle_d      = '0;
            collision_d = collision_q | multi_edge_s;
            if (final_s) begin
              done_d   = 1'b1;
              result_d = RES_DONE;
            end else begin
              done_d   = done_q;
            end
          end else begin
            idle_d = idle_inc_s;
          end
        end
        ST_DONE: begin
          if (bus.done_ack) begin
            done_d = 1'b0;
          end else begin
            done_d = done_q;
          end
        end
        ST_IDLE: idle_d = idle_q;
        default: idle_d = idle_q;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q  <= '0;
      len_lat_q   <= '0;
      seq_q       <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= RES_NONE;
      collision_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      btn_prev_q  <= btn_prev_d;
      len_lat_q   <= len_lat_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      result_q    <= result_d;
      collision_q <= collision_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.seq_out   = seq_q;
  assign bus.seq_cnt   = cnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.collision = collision_q;
endmodule

// File: tb/tb_key_seq_capture.sv
// tb_key_seq_capture: directed bench for key_seq_capture. Main instance uses
// default parameters; a second instance with TIMEOUT_CYC=20 covers idle timeout.
// Expected key codes are queued when a press is driven and popped on key_valid.
module tb_key_seq_capture;
  localparam int NB = 8;
  localparam int ML = 8;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [KW-1:0] sb_q[$];
  logic [KW-1:0] exp_code;

  always #5 clk = ~clk;

  key_seq_capture_if #(.NUM_BTN(NB), .MAX_LEN(ML), .KEY_W(KW)) m ();
  key_seq_capture_if #(.NUM_BTN(NB), .MAX_LEN(ML), .KEY_W(KW)) mt ();

  key_seq_capture #(.NUM_BTN(NB), .MAX_LEN(ML), .KEY_W(KW), .TIMEOUT_CYC(0))
    dut (.clk(clk), .rst(rst), .bus(m));
  key_seq_capture #(.NUM_BTN(NB), .MAX_LEN(ML), .KEY_W(KW), .TIMEOUT_CYC(20))
    dut_t (.clk(clk), .rst(rst), .bus(mt));

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int b, input bit acc);
    m.btn_clean[b] = 1'b1;
    if (acc) sb_q.push_back(KW'(b + 1));
    cyc(1);
  endtask

  task automatic release_all();
    m.btn_clean = '0;
    cyc(1);
  endtask

  task automatic arm_seq(input logic [3:0] len);
    m.len_k = len;
    m.arm   = 1'b1;
    cyc(1);
    m.arm   = 1'b0;
  endtask

  task automatic ack();
    m.done_ack = 1'b1;
    cyc(1);
    m.done_ack = 1'b0;
  endtask

  // Scoreboard: every key_valid must match the oldest queued expected code.
  always @(negedge clk) begin
    if (!rst && m.key_valid) begin
      n_chk++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_key observed=%0h expected=none", m.key_code);
      end
      if (sb_q.size() != 0) begin
        exp_code = sb_q.pop_front();
        n_chk++;
        assert (m.key_code === exp_code) else begin
          n_fail++;
          $error("FAIL sb_key_code observed=%0h expected=%0h", m.key_code, exp_code);
        end
      end
    end
  end

  initial begin
    m.btn_clean = '0; m.arm = 1'b0; m.abort = 1'b0; m.len_k = '0;
    m.time_up = 1'b0; m.done_ack = 1'b0;
    mt.btn_clean = '0; mt.arm = 1'b0; mt.abort = 1'b0; mt.len_k = '0;
    mt.time_up = 1'b0; mt.done_ack = 1'b0;
    cyc(3);
    chk("rst_key_valid", m.key_valid, 0);
    chk("rst_done", m.done, 0);
    chk("rst_result", m.result, 0);
    chk("rst_seq_out", m.seq_out, 0);
    chk("rst_seq_cnt", m.seq_cnt, 0);
    chk("rst_collision", m.collision, 0);
    rst = 1'b0;
    cyc(1);

`ifndef KEY_BACKSPACE_EN
    // Basic 4-key sequence: buttons 2,0,7,3 -> codes 3,1,8,4.
    arm_seq(4'd4);
    chk("t1_armed_done", m.done, 0);
    press(2, 1'b1); chk("t1_cnt1", m.seq_cnt, 1); release_all();
    press(0, 1'b1); chk("t1_cnt2", m.seq_cnt, 2); release_all();
    press(7, 1'b1); chk("t1_cnt3", m.seq_cnt, 3); chk("t1_done_early", m.done, 0); release_all();
    press(3, 1'b1);
    chk("t1_done_with_last", m.done, 1);
    chk("t1_result_with_last", m.result, 2'b01);
    release_all();
    press(1, 1'b0);
    chk("t1_done_ignores_keys", m.seq_cnt, 4);
    release_all();
    ack();
    chk("t1_ack_done", m.done, 0);
    chk("t1_ack_result_kept", m.result, 2'b01);
    chk("t1_seq_out", m.seq_out[15:0], 16'h4813);
`else
    // Backspace: 0,1,backspace,3 -> codes 1,4 left in the sequence.
    arm_seq(4'd4);
    press(0, 1'b1); release_all();
    press(1, 1'b1); release_all();
    press(7, 1'b0);
    chk("bk_cnt_after_bksp", m.seq_cnt, 1);
    chk("bk_no_key_valid", m.key_valid, 0);
    release_all();
    press(3, 1'b1); chk("bk_cnt_final", m.seq_cnt, 2); release_all();
    chk("bk_seq_out", m.seq_out[15:0], 16'h0041);
    arm_seq(4'd4);
    press(7, 1'b0);
    chk("bk_zero_cnt", m.seq_cnt, 0);
    chk("bk_zero_seq", m.seq_out, 0);
    release_all();
    m.abort = 1'b1; cyc(1); m.abort = 1'b0;
`endif

    // Button held through arm is never counted; only the re-press is.
    m.btn_clean[1] = 1'b1;
    arm_seq(4'd2);
    cyc(2);
    chk("t2_held_ignored", m.seq_cnt, 0);
    release_all();
    press(1, 1'b1);
    chk("t2_one_accept", m.seq_cnt, 1);
    chk("t2_code", m.key_code, 2);
    release_all();

    // abort beats a simultaneous arm; sequence is retained, IDLE ignores keys.
    m.abort = 1'b1; m.arm = 1'b1; m.len_k = 4'd4;
    cyc(1);
    m.abort = 1'b0; m.arm = 1'b0;
    chk("ab_done", m.done, 0);
    chk("ab_result", m.result, 0);
    chk("ab_cnt_kept", m.seq_cnt, 1);
    press(2, 1'b0);
    chk("ab_idle_ignores", m.seq_cnt, 1);
    release_all();

    // Simultaneous 5+2 -> code 3 with collision; len 12 clamps to 8.
    arm_seq(4'd12);
    m.btn_clean[5] = 1'b1; m.btn_clean[2] = 1'b1;
    sb_q.push_back(KW'(3));
    cyc(1);
    chk("t3_code", m.key_code, 3);
    chk("t3_collision", m.collision, 1);
    release_all();
    for (int k = 0; k < 7; k++) begin
      press(k, 1'b1);
      chk("t3_done_at_8", m.done, (k == 6) ? 64'd1 : 64'd0);
      release_all();
    end
    chk("t3_cnt", m.seq_cnt, 8);
    chk("t3_seq_out", m.seq_out, 32'h76543213);
    chk("t3_collision_sticky", m.collision, 1);

    // Zero-length arm from DONE finishes at once with cleared outputs.
    arm_seq(4'd0);
    chk("z_done", m.done, 1);
    chk("z_result", m.result, 2'b01);
    chk("z_seq_out", m.seq_out, 0);
    chk("z_collision", m.collision, 0);
    ack();

    // Global timeout coincident with an edge after two keys.
    arm_seq(4'd4);
    press(3, 1'b1); release_all();
    press(4, 1'b1); release_all();
    m.btn_clean[0] = 1'b1; m.time_up = 1'b1;
    cyc(1);
    m.time_up = 1'b0;
    chk("tu_no_key_valid", m.key_valid, 0);
    chk("tu_cnt", m.seq_cnt, 2);
    chk("tu_done", m.done, 1);
    chk("tu_result", m.result, 2'b10);
    release_all();
    ack();

    // Reset mid-capture with a pending edge.
    arm_seq(4'd4);
    press(5, 1'b1); release_all();
    m.btn_clean[6] = 1'b1; rst = 1'b1;
    cyc(1);
    chk("rm_key_valid", m.key_valid, 0);
    chk("rm_cnt", m.seq_cnt, 0);
    chk("rm_seq_out", m.seq_out, 0);
    chk("rm_key_code", m.key_code, 0);
    rst = 1'b0;
    release_all();

    // Idle timeout (TIMEOUT_CYC=20): done 21 cycles after the key_valid cycle.
    mt.len_k = 4'd4; mt.arm = 1'b1;
    cyc(1);
    mt.arm = 1'b0;
    cyc(3);
    mt.btn_clean[0] = 1'b1;
    cyc(1);
    chk("to_key_valid", mt.key_valid, 1);
    chk("to_key_code", mt.key_code, 1);
    mt.btn_clean = '0;
    cyc(20);
    chk("to_not_yet", mt.done, 0);
    cyc(1);
    chk("to_done", mt.done, 1);
    chk("to_result", mt.result, 2'b11);
    chk("to_cnt", mt.seq_cnt, 1);

    cyc(2);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_seq_capture.md
# key_seq_capture

Parametrised key-sequence capture unit. It converts debounced button levels into rising-edge key codes and packs up to MAX_LEN codes into a flat sequence register. It reports completion, global timeout or inter-key idle timeout through a held done/ack handshake. It sits between the debouncer bank and the game FSM / sequence comparator, and generalises the fixed 8-button, 8-entry input stage to arbitrary button count, depth and code width.

## Interface
- NUM_BTN, 8, number of button inputs (≥2)
- MAX_LEN, 8, maximum sequence length (≥1)
- KEY_W, 4, code width; must satisfy 2^KEY_W > NUM_BTN
- TIMEOUT_CYC, 0, inter-key idle timeout in cycles; 0 disables idle timeout
- CNT_W, $clog2(MAX_LEN+1), derived, not overridden
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_clean  in  NUM_BTN  debounced button levels
- arm  in  1  pulse: start new capture (latches len_k)
- abort  in  1  pulse: cancel capture, return to IDLE
- len_k  in  CNT_W  requested sequence length
- time_up  in  1  global round timer expired
- done_ack  in  1  FSM acknowledges done
- key_code  out  KEY_W  code of last accepted key
- key_valid  out  1  one-cycle pulse per accepted key
- seq_out  out  MAX_LEN*KEY_W  packed sequence, entry i at [i*KEY_W +: KEY_W]
- seq_cnt  out  CNT_W  entries captured
- done  out  1  capture finished, held until done_ack
- result  out  2  00 none, 01 complete, 10 global timeout, 11 idle timeout
- collision  out  1  sticky: ≥2 edges in one accepted cycle since arm

## Operation
- Reset: all outputs 0, state IDLE, btn_prev 0.
- Edge detect: edge = btn_clean & ~btn_prev; btn_prev updates every cycle in every state, so buttons already held at arm are never counted.
- States: IDLE, CAPTURE, DONE.
- arm, any state: clear seq_out, seq_cnt, key_code, result, collision, done, idle timer. Latch len_lat = min(len_k, MAX_LEN). If len_lat==0, go to DONE with result 01. Otherwise go to CAPTURE.
- abort, any state, has priority over arm: go to IDLE, done=0, result=00. seq_out and seq_cnt are retained.
- CAPTURE, checked in this priority order:
  - time_up → DONE, result 10; any same-cycle edge is discarded.
  - Idle timer == TIMEOUT_CYC (when nonzero) → DONE, result 11.
  - Any edge → accept the lowest set index b. Code = b+1, written at entry seq_cnt; seq_cnt+1; key_valid=1; idle timer cleared. Other same-cycle edges are dropped and collision is set.
  - Accept that makes seq_cnt == len_lat → DONE, result 01.
- Idle timer: counts in CAPTURE from arm or last accept, saturates; does not run in IDLE/DONE.
- DONE: done=1, edges ignored, outputs frozen; done_ack → IDLE, done=0, result and seq retained.

## Timing
- Edge visible in btn_clean at cycle n: key_valid, key_code, seq_out entry and seq_cnt update at n+1.
- Final key: done=1 and result=01 in the same cycle as its key_valid.
- time_up at cycle n: done=1, result=10 at n+1.
- Idle timeout: with last accept (or arm) at cycle a, done at a+TIMEOUT_CYC+1.
- arm at n: cleared outputs and state CAPTURE at n+1; an edge in cycle n is ignored.
- done_ack at n: done=0 at n+1. done_ack outside DONE is ignored.
- Reset mid-capture: everything returns to reset values next cycle; no partial key_valid.

## Configuration
- KEY_BACKSPACE_EN defined: button NUM_BTN-1 is backspace.
  - Accepted backspace with seq_cnt>0 clears entry seq_cnt-1, decrements seq_cnt and clears the idle timer.
  - No key_valid is issued.
  - At seq_cnt==0 it is ignored and the idle timer is not cleared.
  - Lowest-index priority applies, so backspace loses to any simultaneous key.
- Not defined: button NUM_BTN-1 is an ordinary key with code NUM_BTN.

## Test plan
- Defaults, len_k=4, press btn 2,0,7,3 → key_code 3,1,8,4; seq_out[15:0]=16'h4813; done=1 and result=01 with 4th key_valid; done_ack clears done next cycle.
- btn 1 held through arm, then released and re-pressed → exactly one accept, code 2.
- Press btn 5 and btn 2 in same cycle → code 3 only, collision=1; len_k=12 → clamped to 8.
- time_up coincident with btn 0 edge after 2 keys → no key_valid, seq_cnt=2, result=10.
- TIMEOUT_CYC=20: one key, then no input → done at accept+21, result=11; abort mid-capture → IDLE, result=00.
- KEY_BACKSPACE_EN: keys 1,2, backspace, 3 → seq_out[7:0]=8'h41, seq_cnt=2; backspace at cnt 0 → no change.
